// File: rtl/fft_pkg.sv
// Shared constants and types for the 128-point FFT input reorder stage.
package fft_pkg;
    localparam int LOG2N  = 7;
    localparam int N      = 1 << LOG2N;
    localparam int DATA_W = 16;

    typedef logic [LOG2N-1:0] addr_t;

    localparam addr_t ADDR_ZERO = addr_t'(0);
    localparam addr_t ADDR_ONE  = addr_t'(1);
    localparam addr_t ADDR_LAST = addr_t'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/bitrev_reorder_buffer_if.sv
// Streaming sample bus: natural-order samples in, bit-reversed-order samples out.
interface bitrev_reorder_buffer_if;
    import fft_pkg::*;

    logic [DATA_W-1:0] in_re;
    logic [DATA_W-1:0] in_im;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_re;
    logic [DATA_W-1:0] out_im;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [LOG2N-1:0]  out_index;

    modport master (
        output in_re, in_im, in_valid, out_ready,
        input  in_ready, out_re, out_im, out_valid, out_last, out_index
    );

    modport slave (
        input  in_re, in_im, in_valid, out_ready,
        output in_ready, out_re, out_im, out_valid, out_last, out_index
    );
endinterface

// File: rtl/bit_reverse_index.sv
// Combinational address mirror: bit i of the input lands on bit LOG2N-1-i.
module bit_reverse_index #(
    parameter int LOG2N = 7
) (
    input  logic [LOG2N-1:0] idx_i,
    output logic [LOG2N-1:0] idx_o
);
    // Mirror the address bits
    always_comb begin
        idx_o = {LOG2N{1'b0}};
        for (int i = 0; i < LOG2N; i++) begin
            idx_o[i] = idx_i[LOG2N-1-i];
        end
    end
endmodule

// File: rtl/bitrev_reorder_buffer.sv
// Single-frame reorder buffer: samples are written at bit-reversed addresses during
// FILL and read back in linear order during DRAIN.
module bitrev_reorder_buffer
    import fft_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    bitrev_reorder_buffer_if.slave bus
);
    state_t state_q, state_d;
    addr_t  wr_cnt_q, wr_cnt_d;
    addr_t  rd_cnt_q, rd_cnt_d;
    addr_t  wr_addr_s;
    logic   wr_en_s;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;
    logic   out_last_q, out_last_d;
    logic   busy_q, busy_d;
    logic   frame_done_q, frame_done_d;

    logic [2*DATA_W-1:0] mem_q [N];

    bit_reverse_index #(.LOG2N(LOG2N)) u_wr_rev (
        .idx_i (wr_cnt_q),
        .idx_o (wr_addr_s)
    );

    // Sequencer next state; status outputs are decoded from the next state so they register cleanly
    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        wr_en_s      = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = FILL;
                    wr_cnt_d = ADDR_ZERO;
                end else begin
                    state_d  = IDLE;
                end
            end
            FILL: begin
                if (bus.in_valid && in_ready_q) begin
                    wr_en_s  = 1'b1;
                    wr_cnt_d = wr_cnt_q + ADDR_ONE;
                    if (wr_cnt_q == ADDR_LAST) begin
                        state_d  = DRAIN;
                        rd_cnt_d = ADDR_ZERO;
                    end else begin
                        state_d  = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            DRAIN: begin
                if (bus.out_ready && out_valid_q) begin
                    rd_cnt_d = rd_cnt_q + ADDR_ONE;
                    if (rd_cnt_q == ADDR_LAST) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d  = IDLE;
                wr_cnt_d = ADDR_ZERO;
                rd_cnt_d = ADDR_ZERO;
            end
        endcase
        in_ready_d  = (state_d == FILL);
        out_valid_d = (state_d == DRAIN);
        out_last_d  = (state_d == DRAIN) && (rd_cnt_d == ADDR_LAST);
        busy_d      = (state_d != IDLE);
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wr_cnt_q     <= ADDR_ZERO;
            rd_cnt_q     <= ADDR_ZERO;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Frame storage; deliberately not reset, a new frame overwrites every entry
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= {bus.in_re, bus.in_im};
        end
    end

    assign bus.in_ready             = in_ready_q;
    assign bus.out_valid            = out_valid_q;
    assign bus.out_last             = out_last_q;
    assign bus.out_index            = rd_cnt_q;
    assign {bus.out_re, bus.out_im} = mem_q[rd_cnt_q];
    assign busy                     = busy_q;
    assign frame_done               = frame_done_q;
endmodule

// File: tb/tb_bitrev_reorder_buffer.sv
// Self-checking bench for bitrev_reorder_buffer: table vectors plus a frame-level reference model.
module tb_bitrev_reorder_buffer;
    import fft_pkg::*;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic frame_done;

    bitrev_reorder_buffer_if bif();

    bitrev_reorder_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bif)
    );

    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    int n_pass  = 0;
    int n_total = 0;
    int start_cyc = 0;

    logic signed [DATA_W-1:0] hist_re [N];
    logic signed [DATA_W-1:0] hist_im [N];
    logic signed [DATA_W-1:0] cap_re  [N];
    logic signed [DATA_W-1:0] cap_im  [N];
    logic                     cap_last[N];

    typedef struct {
        int idx;
        int off;
        int last;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle_cnt);
    endtask

    // Reference: output position j carries the input sample whose index is j mirrored.
    function automatic int rev7(input int k);
        int r = 0;
        int v = k;
        for (int i = 0; i < LOG2N; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic apply_table(input int base);
        for (int i = 0; i < 10; i++) begin
            check("tbl_re",   int'(cap_re[tbl[i].idx]), base + tbl[i].off);
            check("tbl_im",   int'(cap_im[tbl[i].idx]), -(base + tbl[i].off));
            check("tbl_last", int'(cap_last[tbl[i].idx]), tbl[i].last);
        end
    endtask

    task automatic run_frame(input int idle_cycles, input bit fill_gaps, input int stall_mode,
                             input bit noise, input bit rand_data, input int base);
        int k;
        int j;
        int cyc;
        bit v;
        bit rdy;
        bit tog;
        for (int i = 0; i < N; i++) begin
            if (rand_data) begin
                hist_re[i] = 16'($urandom);
                hist_im[i] = 16'($urandom);
            end else begin
                hist_re[i] = 16'(base + i);
                hist_im[i] = 16'(-(base + i));
            end
        end
        repeat (idle_cycles) @(negedge clk);
        check("idle_busy", int'(busy), 0);
        start     = 1'b1;
        start_cyc = cycle_cnt;
        @(negedge clk);
        start = 1'b0;
        check("start_busy",       int'(busy), 1);
        check("start_in_ready",   int'(bif.in_ready), 1);
        check("start_frame_done", int'(frame_done), 0);

        k   = 0;
        cyc = 0;
        while (k < N && cyc < 4000) begin
            check("fill_in_ready",  int'(bif.in_ready), 1);
            check("fill_out_valid", int'(bif.out_valid), 0);
            v = fill_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bif.in_valid = v;
            bif.in_re    = v ? hist_re[k] : 16'($urandom);
            bif.in_im    = v ? hist_im[k] : 16'($urandom);
            start        = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (v && bif.in_ready) k++;
            @(negedge clk);
            cyc++;
        end
        check("fill_count", k, N);

        bif.in_valid = noise;
        bif.in_re    = 16'($urandom);
        start        = noise;
        check("first_out_valid", int'(bif.out_valid), 1);
        j   = 0;
        cyc = 0;
        tog = 1'b0;
        while (j < N && cyc < 4000) begin
            check("drain_valid",      int'(bif.out_valid), 1);
            check("drain_in_ready",   int'(bif.in_ready), 0);
            check("drain_re",         int'($signed(bif.out_re)), int'(hist_re[rev7(j)]));
            check("drain_im",         int'($signed(bif.out_im)), int'(hist_im[rev7(j)]));
            check("drain_index",      int'(bif.out_index), j);
            check("drain_last",       int'(bif.out_last), (j == N - 1) ? 1 : 0);
            check("drain_frame_done", int'(frame_done), 0);
            case (stall_mode)
                0:       rdy = 1'b1;
                1:       begin rdy = tog; tog = ~tog; end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bif.out_ready = rdy;
            if (noise) begin
                bif.in_valid = 1'b1;
                bif.in_re    = 16'($urandom);
                start        = (j == N - 1 && rdy) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            if (rdy && bif.out_valid) begin
                cap_re[j]   = $signed(bif.out_re);
                cap_im[j]   = $signed(bif.out_im);
                cap_last[j] = bif.out_last;
                j++;
            end
            @(negedge clk);
            cyc++;
        end
        check("drain_count", j, N);
        bif.out_ready = 1'b0;
        bif.in_valid  = 1'b0;
        start         = 1'b0;
        check("end_frame_done", int'(frame_done), 1);
        check("end_out_valid",  int'(bif.out_valid), 0);
        check("end_busy",       int'(busy), 0);
        check("end_in_ready",   int'(bif.in_ready), 0);
        check("end_out_last",   int'(bif.out_last), 0);
    endtask

    initial begin
        int t0;
        bif.in_re     = 16'd0;
        bif.in_im     = 16'd0;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b0;

        tbl[0] = '{0,   0,   0};
        tbl[1] = '{1,   64,  0};
        tbl[2] = '{2,   32,  0};
        tbl[3] = '{3,   96,  0};
        tbl[4] = '{4,   16,  0};
        tbl[5] = '{5,   80,  0};
        tbl[6] = '{64,  1,   0};
        tbl[7] = '{100, 19,  0};
        tbl[8] = '{126, 63,  0};
        tbl[9] = '{127, 127, 1};

        repeat (3) @(negedge clk);
        check("rst_in_ready",   int'(bif.in_ready), 0);
        check("rst_out_valid",  int'(bif.out_valid), 0);
        check("rst_out_last",   int'(bif.out_last), 0);
        check("rst_busy",       int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_out_index",  int'(bif.out_index), 0);
        rst = 1'b1;
        @(negedge clk);

        run_frame(2, 1'b0, 0, 1'b0, 1'b0, 0);
        apply_table(0);
        run_frame(1, 1'b1, 0, 1'b0, 1'b0, 0);
        apply_table(0);
        run_frame(1, 1'b0, 1, 1'b0, 1'b0, 0);
        apply_table(0);
        run_frame(1, 1'b0, 0, 1'b1, 1'b0, 0);
        apply_table(0);
        run_frame(1, 1'b1, 2, 1'b0, 1'b1, 0);

        // Abort a frame after 50 samples with an asynchronous reset.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            bif.in_valid = 1'b1;
            bif.in_re    = 16'(5000 + k);
            bif.in_im    = 16'(-(5000 + k));
            @(negedge clk);
        end
        check("abort_in_ready_before", int'(bif.in_ready), 1);
        #2 rst = 1'b0;
        #1;
        check("abort_in_ready",   int'(bif.in_ready), 0);
        check("abort_out_valid",  int'(bif.out_valid), 0);
        check("abort_out_last",   int'(bif.out_last), 0);
        check("abort_busy",       int'(busy), 0);
        check("abort_frame_done", int'(frame_done), 0);
        check("abort_out_index",  int'(bif.out_index), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_no_resume",   int'(busy), 0);
        check("abort_idle_ready",  int'(bif.in_ready), 0);
        bif.in_valid = 1'b0;
        run_frame(1, 1'b0, 0, 1'b0, 1'b0, 1000);
        apply_table(1000);

        // Back-to-back frames: second start driven as soon as frame_done is seen.
        run_frame(1, 1'b0, 0, 1'b0, 1'b1, 0);
        t0 = start_cyc;
        run_frame(0, 1'b0, 0, 1'b0, 1'b1, 0);
        check("frame_period", start_cyc - t0, 2 * N + 1);
        @(negedge clk);
        check("post_frame_done", int'(frame_done), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
